// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the bimodal branch predictor
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  // Tag field sized for the smallest legal table (4 entries); narrower tags are zero-extended.
  localparam int TAG_MAX_W = 28;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-state function
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t cur,
  input  logic inc,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (inc) begin
      if (cur != CTR_ST) nxt = ctr_t'(cur + 2'd1);
    end else begin
      if (cur != CTR_SNT) nxt = ctr_t'(cur - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal predictor + BTB feeding the fetch stage
// Optional gshare counter indexing when BRANCH_PREDICTOR_GSHARE_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iaddr,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  output logic [31:0] mispred_cnt
);

  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];
  ctr_t       ctr_q [ENTRIES];
  ctr_t       ctr_d [ENTRIES];
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]     l_idx, l_cidx, u_idx, u_cidx;
  logic [TAG_MAX_W-1:0] l_tag, u_tag;
  logic                 l_hit, u_hit;
  ctr_t                 u_ctr_nxt;
  logic [1:0]           unused_upd_lsb;

  assign unused_upd_lsb = upd_pc[1:0];

  assign l_idx = iaddr[IDX_W+1:2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign l_tag = TAG_MAX_W'(iaddr[31:IDX_W+2]);
  assign u_tag = TAG_MAX_W'(upd_pc[31:IDX_W+2]);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  localparam int GHR_W = (IDX_W < 4) ? IDX_W : 4;
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // Only the counter table is hashed with history; tag/target stay PC-indexed.
  assign l_cidx = l_idx ^ IDX_W'(ghr_q);
  assign u_cidx = u_idx ^ IDX_W'(ghr_q);

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = {ghr_q[GHR_W-2:0], upd_taken};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  assign l_cidx = l_idx;
  assign u_cidx = u_idx;
`endif

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign l_hit       = btb_q[l_idx].valid && (btb_q[l_idx].tag == l_tag);
  assign pred_taken  = l_hit && ctr_q[l_cidx][1];
  assign pred_target = pred_taken ? btb_q[l_idx].target : iaddr + 32'd4;
  assign mispred_cnt = mispred_cnt_q;

  assign u_hit = btb_q[u_idx].valid && (btb_q[u_idx].tag == u_tag);

  sat_counter2 u_sat (
    .cur (ctr_q[u_cidx]),
    .inc (upd_taken),
    .nxt (u_ctr_nxt)
  );

  always_comb begin
    btb_d = btb_q;
    ctr_d = ctr_q;
    if (upd_valid) begin
      if (u_hit) begin
        ctr_d[u_cidx] = u_ctr_nxt;
        if (upd_taken) btb_d[u_idx].target = upd_target;
      end else if (upd_taken) begin
        btb_d[u_idx].valid  = 1'b1;
        btb_d[u_idx].tag    = u_tag;
        btb_d[u_idx].target = upd_target;
        ctr_d[u_cidx]       = CTR_ALLOC;
      end
    end
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid && upd_mispred && (mispred_cnt_q != 32'hFFFF_FFFF))
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
        ctr_q[i] <= CTR_RESET;
      end
      mispred_cnt_q <= '0;
    end else begin
      btb_q         <= btb_d;
      ctr_q         <= ctr_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iaddr;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] mispred_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predictor dut (
    .clk         (clk),
    .reset       (reset),
    .iaddr       (iaddr),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = tk;
    upd_target  = tgt;
    upd_mispred = mp;
    step();
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] a);
    iaddr = a;
    #1;
  endtask

  initial begin
    reset = 1'b1; iaddr = 32'h40;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
    step(); step();
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_target", pred_target, 32'h44);
    chk("rst_cnt", mispred_cnt, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_taken", {31'd0, pred_taken}, 32'd0);

    // allocate 0x40 -> 0x100; same-cycle lookup still sees the empty entry
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
    #1;
    chk("alloc_same_cycle", {31'd0, pred_taken}, 32'd0);
    step();
    upd_valid = 1'b0;
    #1;
    chk("alloc_taken", {31'd0, pred_taken}, 32'd1);
    chk("alloc_target", pred_target, 32'h100);
    look(32'h80);
    chk("alias_taken", {31'd0, pred_taken}, 32'd0);
    chk("alias_target", pred_target, 32'h84);

    // 10 -> 01 -> 00 -> 00
    look(32'h40);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    chk("nt1_taken", {31'd0, pred_taken}, 32'd0);
    chk("nt1_target", pred_target, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    chk("nt3_taken", {31'd0, pred_taken}, 32'd0);
    // 00 -> 01 (still not taken) -> 10 with retrained target
    upd(32'h40, 1'b1, 32'h200, 1'b0);
    chk("t1_taken", {31'd0, pred_taken}, 32'd0);
    upd(32'h40, 1'b1, 32'h200, 1'b0);
    chk("t2_taken", {31'd0, pred_taken}, 32'd1);
    chk("t2_target", pred_target, 32'h200);
    // 10 -> 11 -> 11, then one not-taken leaves 10
    upd(32'h40, 1'b1, 32'h200, 1'b0);
    upd(32'h40, 1'b1, 32'h200, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    chk("sat_hi_taken", {31'd0, pred_taken}, 32'd1);
    look(32'h43);
    chk("lsb_ignored_target", pred_target, 32'h200);

    // not-taken miss at aliasing index leaves 0x40 entry intact
    upd(32'h80, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    chk("miss_nt_keep", {31'd0, pred_taken}, 32'd1);
    look(32'h80);
    chk("miss_nt_noalloc", {31'd0, pred_taken}, 32'd0);

    // same-cycle lookup/update: old prediction now, new one next cycle
    look(32'h40);
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0; upd_target = '0;
    #1;
    chk("bypass_old", {31'd0, pred_taken}, 32'd1);
    step();
    upd_valid = 1'b0;
    #1;
    chk("bypass_new", {31'd0, pred_taken}, 32'd0);

    upd(32'h40, 1'b1, 32'h200, 1'b0);
    chk("retake_taken", {31'd0, pred_taken}, 32'd1);

    // five qualified mispredicts and one unqualified
    for (int i = 0; i < 5; i++) upd(32'h1000, 1'b0, 32'h0, 1'b1);
    upd_mispred = 1'b1;
    step();
    upd_mispred = 1'b0;
    #1;
    chk("mispred_cnt", mispred_cnt, 32'd5);
    chk("mispred_keep_pred", {31'd0, pred_taken}, 32'd1);

    // asynchronous reset between clock edges
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cnt", mispred_cnt, 32'd0);
    chk("async_rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("async_rst_target", pred_target, 32'h44);

    // update pending as reset drops is applied at the first edge
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h300; upd_mispred = 1'b1;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispred = 1'b0;
    #1;
    chk("rst_edge_taken", {31'd0, pred_taken}, 32'd1);
    chk("rst_edge_target", pred_target, 32'h300);
    chk("rst_edge_cnt", mispred_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor with branch target buffer (BTB) that sits directly upstream of the pipelined CPU's fetch stage. Each cycle it looks up the fetch PC and supplies a taken/not-taken prediction and next-fetch target. The execute stage feeds back resolved branch outcomes, which train 2-bit saturating counters and BTB entries. A saturating misprediction counter is kept for debug and performance observation.

## Interface
- ENTRIES, 16: number of predictor entries; power of two, 4..256.
- IDX_W, $clog2(ENTRIES): index width; index = PC[IDX_W+1:2].
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- iaddr  in  32  fetch PC from the IF stage.
- pred_taken  out  1  1 = BTB hit and counter MSB set.
- pred_target  out  32  BTB target if pred_taken, else iaddr+4.
- upd_valid  in  1  EX stage has resolved a branch/jump this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual taken target.
- upd_mispred  in  1  EX detected a misprediction; qualified by upd_valid.
- mispred_cnt  out  32  saturating count of mispredictions.

## Operation
- Per entry: valid (1), tag (PC[31:IDX_W+2]), target (32), ctr (2). Encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup: combinational over registered state. hit = valid && tag match; pred_taken = hit && ctr[1]; pred_target = pred_taken ? target : iaddr+4 (mod 2^32).
- Update when upd_valid, at the upd_pc entry:
  - Tag hit: ctr saturating +1 if upd_taken, else -1. If upd_taken, overwrite target with upd_target.
  - Miss and upd_taken: allocate. valid=1, tag and target written, ctr=10 (WT).
  - Miss and not taken: no state change.
- mispred_cnt increments on upd_valid && upd_mispred and saturates at 0xFFFF_FFFF.
- upd_mispred without upd_valid is ignored.
- Low two bits of iaddr/upd_pc are ignored.

## Timing
- Prediction has zero latency: same-cycle combinational from iaddr.
- Update is written at the rising clk edge. It becomes visible to lookup in the next cycle.
- Simultaneous lookup and update to the same index: lookup returns pre-update state, with no bypass.
- Reset (asynchronous, at any time, including mid-update): all valid=0, all ctr=01, mispred_cnt=0, GHR=0 (when configured).
  - During and after reset, pred_taken=0 and pred_target=iaddr+4.
  - An update coincident with reset deassertion's first edge is applied normally.
- Counter saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.

## Configuration
- BRANCH_PREDICTOR_GSHARE_EN defined:
  - Adds a 4-bit (or IDX_W if smaller) global history register.
  - ctr is indexed by PC index XOR GHR. Tag/target arrays are still indexed by plain PC index.
  - On upd_valid, the update uses the current GHR, then GHR <= {GHR[n-2:0], upd_taken} at the same edge.
- Undefined: pure bimodal; no GHR exists; ctr shares the plain PC index.

## Structure
- Package bp_pkg holds:
  - ctr encodings (CTR_SNT/WNT/WT/ST) and the ctr_t typedef;
  - the reset value CTR_RESET = WNT and allocate value CTR_ALLOC = WT;
  - the btb_entry_t struct (valid, tag, target).
- One sub-module, sat_counter2: 2-bit saturating next-state function (inc/dec with clamp), instantiated once on the update path.

## Test plan
- Reset with iaddr=0x40 -> pred_taken=0, pred_target=0x44, mispred_cnt=0.
- Update pc=0x40, taken, target=0x100; next cycle iaddr=0x40 -> pred_taken=1, pred_target=0x100. Then iaddr=0x80 (alias index, different tag) -> pred_taken=0, pred_target=0x84.
- Three not-taken updates at 0x40 after allocation -> ctr 10→01→00→00; pred_taken=0 after the first. Two taken updates -> ctr 01, then 10; pred_taken=1 again.
- Lookup and update of 0x40 in the same cycle -> old prediction that cycle, new one the next cycle.
- Five upd_valid&&upd_mispred pulses plus one upd_mispred with upd_valid=0 -> mispred_cnt=5. Assert reset mid-stream -> mispred_cnt=0 and all predictions not-taken immediately (asynchronous).
- GSHARE_EN: update pc=0x40 taken twice -> GHR=0011. Lookup at 0x40 uses index 0000^0011 for ctr; tag/target still hit.
